// File: rtl/note_sequencer.sv
// note_sequencer: note-code source for the DE1-SoC player's seven-segment decoder
// and square-wave tone generator.
//   Manual mode (IDLE): the switch code is registered straight through.
//   Play mode: steps an 8-note scale (DO1..DO2) with a programmable note length,
//   a silent gap at the end of every note, pause/resume, stop and loop.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sw[3:0]            manual note code (used in IDLE only)
//   start/stop/pause   1-cycle control pulses (priority stop > pause > start)
//   loop_en            replay from step 0 after step 7
//   tempo_sel[1:0]     note length = NOTE_BASE << tempo_sel ticks
//   note_code[3:0]     code for display decoder and tone gen (bit0 = sound)
//   half_period[16:0]  tone half-period in clk cycles, 0 = silent
//   step_idx[2:0]      current melody step
//   busy               high in NOTE, GAP, PAUSED
//   done               1-cycle pulse on natural end of the melody
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned NOTE_BASE = 125,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        loop_en,
  input  logic [1:0]  tempo_sel,
  output logic [3:0]  note_code,
  output logic [16:0] half_period,
  output logic [2:0]  step_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Longest note is NOTE_BASE << 3 ticks.
  localparam int unsigned TICK_W  = $clog2(NOTE_BASE * 8 + 1);
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned HP_W    = 17;
  localparam int unsigned STEP_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NOTE   = 2'd1,
    S_GAP    = 2'd2,
    S_PAUSED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  state_e              saved_q, saved_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [TICK_W-1:0]   len_q, len_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CODE_W-1:0]   note_code_q, note_code_d;
  logic [HP_W-1:0]     half_period_q, half_period_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                presc_last_c;
  logic                expire_c;
  logic [TICK_W-1:0]   tick_end_c;
  logic [TICK_W-1:0]   len_sel_c;

  // Scale step to note code (DO1 .. DO2).
  function automatic logic [CODE_W-1:0] scale_code(input logic [STEP_W-1:0] s);
    logic [CODE_W-1:0] c;
    case (s)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0011;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1001;
      3'd4:    c = 4'b0111;
      3'd5:    c = 4'b1011;
      3'd6:    c = 4'b1101;
      default: c = 4'b1111;
    endcase
    return c;
  endfunction

  // Note code to tone half-period at 50 MHz; bit0 clear means silent.
  function automatic logic [HP_W-1:0] hp_decode(input logic [CODE_W-1:0] code);
    logic [HP_W-1:0] hp;
    case (code)
      4'b0001: hp = 17'd95556;
      4'b0011: hp = 17'd85131;
      4'b0101: hp = 17'd75843;
      4'b1001: hp = 17'd71586;
      4'b0111: hp = 17'd63776;
      4'b1011: hp = 17'd56818;
      4'b1101: hp = 17'd50619;
      4'b1111: hp = 17'd47778;
      default: hp = '0;
    endcase
    return hp;
  endfunction

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      saved_q       <= S_IDLE;
      presc_q       <= '0;
      tick_q        <= '0;
      len_q         <= '0;
      step_q        <= '0;
      note_code_q   <= '0;
      half_period_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_q       <= saved_d;
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      len_q         <= len_d;
      step_q        <= step_d;
      note_code_q   <= note_code_d;
      half_period_q <= half_period_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state, timer and output decode.
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    presc_d       = presc_q;
    tick_d        = tick_q;
    len_d         = len_q;
    step_d        = step_q;
    done_d        = 1'b0;
    note_code_d   = '0;
    half_period_d = '0;
    busy_d        = 1'b0;

    presc_last_c = (presc_q == PRESC_W'(TICK_DIV - 1));
    tick_end_c   = (state_q == S_NOTE) ? (len_q - TICK_W'(1)) : TICK_W'(GAP_TICKS - 1);
    expire_c     = presc_last_c && (tick_q == tick_end_c);
    len_sel_c    = (TICK_W'(NOTE_BASE) << tempo_sel) - TICK_W'(GAP_TICKS);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_NOTE;
          step_d  = '0;
          presc_d = '0;
          tick_d  = '0;
          len_d   = len_sel_c;
        end
      end

      S_NOTE, S_GAP: begin
        if (presc_last_c) begin
          presc_d = '0;
          tick_d  = tick_q + TICK_W'(1);
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        if (expire_c) begin
          presc_d = '0;
          tick_d  = '0;
          if (state_q == S_NOTE) begin
            state_d = S_GAP;
          end else if ((step_q != 3'd7) || loop_en) begin
            // Step 7 wraps to 0 when looping.
            state_d = S_NOTE;
            step_d  = step_q + STEP_W'(1);
            len_d   = len_sel_c;
          end else begin
            state_d = S_IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end
        end
        // The expiring transition completes first; pause then parks in the new state.
        if (pause && (state_d != S_IDLE)) begin
          saved_d = state_d;
          state_d = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (pause) begin
          state_d = saved_q;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d = S_IDLE;
      step_d  = '0;
      presc_d = '0;
      tick_d  = '0;
      done_d  = 1'b0;
    end

    case (state_d)
      S_IDLE:  note_code_d = sw;
      S_NOTE:  note_code_d = scale_code(step_d);
      default: note_code_d = '0;
    endcase
    half_period_d = hp_decode(note_code_d);
    busy_d        = (state_d != S_IDLE);
  end

  assign note_code   = note_code_q;
  assign half_period = half_period_q;
  assign step_idx    = step_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed self-checking bench for note_sequencer with
// TICK_DIV=4, NOTE_BASE=8, GAP_TICKS=2 (note 24 cycles + gap 8 cycles at tempo 00).
module tb_note_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sw;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [1:0]  tempo_sel;
  logic [3:0]  note_code;
  logic [16:0] half_period;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [3:0]  scale_t [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b1001,
                               4'b0111, 4'b1011, 4'b1101, 4'b1111};
  logic [16:0] hp_t    [8] = '{17'd95556, 17'd85131, 17'd75843, 17'd71586,
                               17'd63776, 17'd56818, 17'd50619, 17'd47778};

  note_sequencer #(
    .TICK_DIV (4),
    .NOTE_BASE(8),
    .GAP_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .tempo_sel  (tempo_sel),
    .note_code  (note_code),
    .half_period(half_period),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ec, input logic [16:0] eh,
                         input logic [2:0] es, input logic eb, input logic ed);
    chk({tag, ".note_code"},   32'(note_code),   32'(ec));
    chk({tag, ".half_period"}, 32'(half_period), 32'(eh));
    chk({tag, ".step_idx"},    32'(step_idx),    32'(es));
    chk({tag, ".busy"},        32'(busy),        32'(eb));
    chk({tag, ".done"},        32'(done),        32'(ed));
  endtask

  // Expected outputs j cycles after the start edge at tempo 00 (32-cycle steps).
  task automatic chk_play(input string tag, input int j);
    logic [2:0] s;
    logic       in_note;
    s       = 3'((j / 32) % 8);
    in_note = (j % 32) < 24;
    chk_out(tag, in_note ? scale_t[s] : 4'd0, in_note ? hp_t[s] : 17'd0, s, 1'b1, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    sw        = 4'b1011;
    start     = 1'b0;
    stop      = 1'b0;
    pause     = 1'b0;
    loop_en   = 1'b0;
    tempo_sel = 2'b00;

    // Reset and manual mode
    repeat (3) @(negedge clk);
    chk_out("reset", 4'd0, 17'd0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("manual_1011", 4'b1011, 17'd56818, 3'd0, 1'b0, 1'b0);
    sw = 4'b1010;
    @(negedge clk);
    chk_out("manual_1010", 4'b1010, 17'd0, 3'd0, 1'b0, 1'b0);
    pause = 1'b1;
    sw    = 4'b0111;
    @(negedge clk);
    pause = 1'b0;
    chk_out("idle_pause_ignored", 4'b0111, 17'd63776, 3'd0, 1'b0, 1'b0);

    // Full melody, no loop
    sw = 4'd0;
    pulse_start();
    for (int j = 0; j < 256; j++) begin
      chk_play("melody", j);
      @(negedge clk);
    end
    chk_out("melody_done", 4'd0, 17'd0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("done_clear", 4'd0, 17'd0, 3'd0, 1'b0, 1'b0);

    // Tempo 10: 120-cycle note; mid-note change applies from the next note
    tempo_sel = 2'b10;
    pulse_start();
    for (int j = 0; j <= 152; j++) begin
      if (j == 50) tempo_sel = 2'b00;
      if (j < 120)      chk_out("tempo_note0", 4'b0001, 17'd95556, 3'd0, 1'b1, 1'b0);
      else if (j < 128) chk_out("tempo_gap0",  4'd0,    17'd0,     3'd0, 1'b1, 1'b0);
      else if (j < 152) chk_out("tempo_note1", 4'b0011, 17'd85131, 3'd1, 1'b1, 1'b0);
      else              chk_out("tempo_gap1",  4'd0,    17'd0,     3'd1, 1'b1, 1'b0);
      @(negedge clk);
    end
    sw   = 4'b0101;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_out("tempo_stop", 4'b0101, 17'd75843, 3'd0, 1'b0, 1'b0);

    // Pause after 10 cycles of step 0, hold 50 cycles, resume for the remaining 14
    sw = 4'd0;
    pulse_start();
    for (int j = 0; j < 10; j++) begin
      chk_play("pause_pre", j);
      if (j == 9) pause = 1'b1;
      @(negedge clk);
    end
    pause = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk_out("paused", 4'd0, 17'd0, 3'd0, 1'b1, 1'b0);
      if (i == 49) pause = 1'b1;
      @(negedge clk);
    end
    pause = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk_out("resumed", 4'b0001, 17'd95556, 3'd0, 1'b1, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk_out("resumed_gap", 4'd0, 17'd0, 3'd0, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_out("resumed_step1", 4'b0011, 17'd85131, 3'd1, 1'b1, 1'b0);

    // stop + pause together during NOTE: stop wins
    sw    = 4'b0101;
    stop  = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    pause = 1'b0;
    chk_out("stop_pause", 4'b0101, 17'd75843, 3'd0, 1'b0, 1'b0);
    sw = 4'b1001;
    @(negedge clk);
    chk_out("stop_pause_idle", 4'b1001, 17'd71586, 3'd0, 1'b0, 1'b0);

    // Pause on the cycle the NOTE timer expires: parks in GAP
    sw = 4'd0;
    pulse_start();
    for (int j = 0; j < 24; j++) begin
      chk_play("expiry_pre", j);
      if (j == 23) pause = 1'b1;
      @(negedge clk);
    end
    pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("expiry_paused", 4'd0, 17'd0, 3'd0, 1'b1, 1'b0);
      if (i == 4) pause = 1'b1;
      @(negedge clk);
    end
    pause = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out("expiry_gap", 4'd0, 17'd0, 3'd0, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_out("expiry_step1", 4'b0011, 17'd85131, 3'd1, 1'b1, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_out("expiry_stop", 4'd0, 17'd0, 3'd0, 1'b0, 1'b0);

    // Loop: wraps to step 0 with no done; start mid-play ignored
    loop_en = 1'b1;
    pulse_start();
    for (int j = 0; j < 264; j++) begin
      chk_play("loop", j);
      start = (j == 40);
      @(negedge clk);
    end
    start = 1'b0;
    sw    = 4'b1111;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_out("loop_stop", 4'b1111, 17'd47778, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-play
    loop_en = 1'b0;
    pulse_start();
    repeat (40) @(negedge clk);
    chk_out("pre_reset", 4'b0011, 17'd85131, 3'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'd0, 17'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("post_reset", 4'b1111, 17'd47778, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
